// File: rtl/token_divider_pkg.sv
// Shared constants, emit-phase type and ratio clamp used by the token divider.
package token_div_pkg;

  localparam int unsigned DEFAULT_RATIO = 2;

  typedef enum logic {
    EMIT_LAST  = 1'b0,
    EMIT_FIRST = 1'b1
  } emit_phase_e;

  // Raw ratios of 0 or 1 mean pass-through; anything above the maximum saturates.
  function automatic int unsigned clamp_ratio(input int unsigned raw,
                                              input int unsigned max_ratio);
    if (raw <= 1) begin
      return 1;
    end else if (raw > max_ratio) begin
      return max_ratio;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/token_divider_if.sv
// Token, configuration and status signals of the token divider.
interface token_divider_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_RATIO = 8
);
  localparam int unsigned CW = $clog2(MAX_RATIO + 1);

  logic [NUM_CH-1:0] a;
  logic              cfg_we;
  logic [CW-1:0]     cfg_ratio;
  logic              cfg_first;
  logic              clear;
  logic [NUM_CH-1:0] b;
  logic [NUM_CH-1:0] pending;
  logic [CW-1:0]     ratio_q;

  modport master (
    output a, cfg_we, cfg_ratio, cfg_first, clear,
    input  b, pending, ratio_q
  );

  modport slave (
    input  a, cfg_we, cfg_ratio, cfg_first, clear,
    output b, pending, ratio_q
  );
endinterface

// File: rtl/token_divider_ch.sv
// One decimator channel: token counter with first/last emit selection.
module token_div_ch
  import token_div_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_i,
  input  logic        flush_i,
  input  logic [CW-1:0] ratio_i,
  input  emit_phase_e first_i,
  output logic        b_o,
  output logic        pending_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          b_q, b_d;
  logic          pend_q, pend_d;
  logic          group_end;

  // With ratio 1 the counter sits at 0, so every token both opens and closes a group.
  assign group_end = (cnt_q == (ratio_i - CW'(1)));

  always_comb begin
    cnt_d = cnt_q;
    b_d   = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (a_i) begin
      b_d   = (first_i == EMIT_FIRST) ? (cnt_q == '0) : group_end;
      cnt_d = group_end ? '0 : cnt_q + CW'(1);
    end
    pend_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      b_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      b_q    <= b_d;
      pend_q <= pend_d;
    end
  end

  assign b_o       = b_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/token_divider.sv
// Multi-channel token decimator: passes one of every ratio_q tokens per channel.
module token_divider
  import token_div_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_RATIO = 8
) (
  input logic              clk,
  input logic              rst,
  token_divider_if.slave   bus
);

  localparam int unsigned CW = $clog2(MAX_RATIO + 1);

  logic [CW-1:0]     ratio_q, ratio_d;
  emit_phase_e       first_q, first_d;
  logic              flush;
  logic [NUM_CH-1:0] b_w;
  logic [NUM_CH-1:0] pend_w;

  // A config write also clears the counters so they never exceed the new ratio.
  assign flush = bus.cfg_we | bus.clear;

  always_comb begin
    ratio_d = ratio_q;
    first_d = first_q;
    if (bus.cfg_we) begin
      ratio_d = CW'(clamp_ratio(32'(bus.cfg_ratio), MAX_RATIO));
      first_d = emit_phase_e'(bus.cfg_first);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_q <= CW'(DEFAULT_RATIO);
      first_q <= EMIT_LAST;
    end else begin
      ratio_q <= ratio_d;
      first_q <= first_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    token_div_ch #(.CW(CW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a_i       (bus.a[i]),
      .flush_i   (flush),
      .ratio_i   (ratio_q),
      .first_i   (first_q),
      .b_o       (b_w[i]),
      .pending_o (pend_w[i])
    );
  end

  assign bus.b       = b_w;
  assign bus.pending = pend_w;
  assign bus.ratio_q = ratio_q;

endmodule

// File: doc/token_divider.md
Name: token_divider

Overview:
- Multi-channel serial token decimator: of every RATIO '1' tokens seen on a channel, exactly one is passed through; all others are dropped.
- The ratio and the emit phase (first or last token of each group) are programmable at run time.
- Generalises the fixed halve-by-two token block to N channels, a ratio of 1..MAX_RATIO, a selectable emit phase and per-channel pending status.
- Sits in serial token/pulse paths such as event thinning and rate reduction ahead of counters.

Parameters:
- NUM_CH, 4, number of independent token channels
- MAX_RATIO, 8, largest supported ratio; must be >= 2
- CW, $clog2(MAX_RATIO+1), width of the ratio field and per-channel counters (derived; do not override)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  NUM_CH  token inputs; a '1' in a cycle is one token on that channel
- cfg_we  in  1  configuration write strobe
- cfg_ratio  in  CW  requested ratio, sampled when cfg_we=1
- cfg_first  in  1  emit-phase select, sampled when cfg_we=1: 1 = emit the first token of each group, 0 = emit the last
- clear  in  1  synchronous clear of all channel counters
- b  out  NUM_CH  decimated tokens, registered
- pending  out  NUM_CH  channel has a partially filled group (counter != 0), registered
- ratio_q  out  CW  effective ratio currently in use

Behaviour:
- Reset (async assert, sync release):
  - b=0, pending=0, all counters=0
  - ratio_q=2, first_q=0, so the block defaults to the halve-by-two, emit-last behaviour
- Ratio effective value:
  - cfg_ratio 0 or 1 -> ratio_q=1 (pass-through)
  - cfg_ratio > MAX_RATIO -> ratio_q=MAX_RATIO (clamp)
  - otherwise ratio_q=cfg_ratio
- Config write:
  - On a cycle with cfg_we=1, ratio_q/first_q update at the clock edge and all counters go to 0.
  - Tokens on a in that same cycle are discarded: b=0 next cycle for all channels.
- clear=1 without cfg_we: all counters go to 0, tokens in that cycle are discarded, config is unchanged.
- If cfg_we and clear are both 1, the config write applies; the outcome is identical for the counters.
- Per channel i, evaluated each cycle when neither cfg_we nor clear is asserted:
  - a[i]=0: counter holds, b[i]<=0.
  - a[i]=1, emit-last (first_q=0): if counter==ratio_q-1 then b[i]<=1 and counter<=0; else b[i]<=0 and counter<=counter+1.
  - a[i]=1, emit-first (first_q=1): b[i]<=(counter==0); counter<=(counter==ratio_q-1) ? 0 : counter+1.
  - ratio_q=1: b[i]<=a[i] in both modes, counter stays 0.
- Latency: exactly one cycle from a token on a to the corresponding pulse on b. b is high for one cycle per emitted token, so back-to-back emissions are allowed.
- pending[i] is registered and equals (next counter value != 0), i.e. it is valid in the same cycle as b.
- Channels are fully independent; there are no cross-channel interactions.
- Counters never exceed ratio_q-1, so there is no wrap-around beyond the programmed ratio.
- Reset asserted mid-group drops the partial count; no token is emitted for it.

Decomposition:
- Package token_div_pkg holds:
  - the reset-default ratio constant (2)
  - the emit-phase constants EMIT_LAST=0, EMIT_FIRST=1
  - the clamp function that maps a raw ratio to its effective value
- One sub-module, token_div_ch: single-channel counter plus emit logic, taking ratio_q and first_q as inputs.
  - The top level holds the config registers, clear/cfg_we gating, and a generate loop of NUM_CH instances.

Test Plan:
- Reset defaults, channel 0: a=110_011_101_000_1111 -> b=010_001_001_000_0101, delayed one cycle; pending goes high after each odd token.
- cfg_ratio=3, emit-last, ch1 gets 7 consecutive ones -> b[1] pulses on the 3rd and 6th tokens only; pending[1]=1 after the 7th.
- cfg_ratio=3, cfg_first=1, ch2 gets 6 ones spread over idle cycles -> b[2] pulses on the 1st and 4th tokens.
- cfg_ratio=0 then cfg_ratio=15 (MAX_RATIO=8) -> ratio_q reads 1 (b equals a, delayed one cycle), then 8 (one emit per 8 tokens).
- Mid-group: 1 token on ch0 at ratio 2, then clear, then 2 tokens -> single b pulse on the 2nd post-clear token; a token in the clear cycle is not emitted.
- Async reset asserted off-edge mid-group with all channels active -> b and pending go to 0 immediately; next group count starts from zero.
